config_reg_bank: RTL and testbench
==================================

Name: config_reg_bank

Overview:
- Parameterised bank of NUM_REGS configuration registers for the packet-routing interconnect.
- Decodes address/op/payload request messages on a val/rdy input and applies writes or reads.
- Returns one response per accepted request through a 2-entry response FIFO, so the bank sustains one request per cycle without a combinational path from send_rdy to recv_rdy.
- Drives all register contents in parallel to the router datapath.

Parameters:
- ADDR_SIZE, 4, width of address field.
- PAYLOAD_SIZE, 8, width of data field and of each register.
- NUM_REGS, 4, number of registers; legal range 1..2^ADDR_SIZE.
- BASE_ADDR, 0, address of register 0; BASE_ADDR+NUM_REGS <= 2^ADDR_SIZE.
- RESET_VALUE, 0, PAYLOAD_SIZE-bit reset value of every register.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- recv_val  in  1  request valid.
- recv_rdy  out  1  request ready.
- recv_msg  in  ADDR_SIZE+PAYLOAD_SIZE+1  request {addr, op, payload}; op=1 write, op=0 read.
- send_val  out  1  response valid.
- send_rdy  in  1  response ready.
- send_msg  out  ADDR_SIZE+PAYLOAD_SIZE+1  response {addr, hit, data}.
- cfg_out  out  NUM_REGS*PAYLOAD_SIZE  register i at bits [i*PAYLOAD_SIZE +: PAYLOAD_SIZE].
- cfg_written  out  NUM_REGS  bit i set once register i has been written since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion):
  - All registers = RESET_VALUE; cfg_written = 0.
  - FIFO emptied: count=0, read/write pointers=0.
  - Outputs: send_val=0, recv_rdy=1, send_msg=0.
  - Reset mid-transaction drops all queued responses; no partial write survives.
- Handshakes:
  - A request is accepted on a rising edge with recv_val && recv_rdy.
  - A response is consumed on a rising edge with send_val && send_rdy.
  - recv_rdy = (count < 2), registered state only; it does not depend on send_rdy.
  - send_val = (count != 0); send_msg = FIFO head, held stable while send_val && !send_rdy.
- Decode:
  - offset = addr - BASE_ADDR, computed modulo ADDR_SIZE bits.
  - hit = (addr >= BASE_ADDR) && (offset < NUM_REGS).
- Accept, write hit:
  - reg[offset] <= payload; cfg_written[offset] <= 1.
  - Enqueue {addr, 1, payload}.
- Accept, read hit: registers unchanged; enqueue {addr, 1, reg[offset]}.
- Accept, miss (either op): no state change; enqueue {addr, 0, 0}.
- Latency:
  - Response is valid in the cycle after acceptance (1 cycle).
  - cfg_out reflects a write in the cycle after acceptance.
- FIFO: 2 entries, in-order, pointers wrap mod 2.
  - Simultaneous enqueue and dequeue: count unchanged, pointers both advance.
  - At count=2 a dequeue in the same cycle does not allow an enqueue; recv_rdy goes high the following cycle.
- Read-after-write to the same register in back-to-back cycles returns the written value.
- No X on outputs after reset; recv_msg is ignored when not accepted.

Test Plan:
- Reset then write addr 2, data 0xA5, op=1 → next cycle send_msg={2,1,0xA5}, send_val=1; cfg_out[23:16]=0xA5, cfg_written=4'b0100.
- Write addr 1 ← 0x3C, then read addr 1 back-to-back with send_rdy=1 → responses {1,1,0x3C} and {1,1,0x3C} on consecutive cycles; full throughput with recv_rdy held at 1.
- Read addr 9 (outside 0..3), and write addr 9 ← 0xFF → responses {9,0,0x00} for each; cfg_out and cfg_written unchanged.
- send_rdy=0, three requests offered → first two accepted, recv_rdy=0 after the second; send_msg holds the first response; after send_rdy=1 for one cycle, recv_rdy=1 the next cycle and the third request is accepted; all responses are returned in order.
- BASE_ADDR=4, NUM_REGS=3: write addr 6 ← 0x11 → hit, register 2 = 0x11; write addr 7 → miss; write addr 3 → miss (wrap guard).
- Two responses queued, reset asserted asynchronously mid-cycle → send_val=0 and recv_rdy=1 immediately; cfg_out = RESET_VALUE for all registers; no stale responses appear after reset is released.

Source files
------------

// File: rtl/config_reg_bank.sv
// config_reg_bank: val/rdy-addressed configuration registers with a 2-entry response FIFO
module config_reg_bank #(
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8,
    parameter int NUM_REGS     = 4,
    parameter int BASE_ADDR    = 0,
    parameter logic [PAYLOAD_SIZE-1:0] RESET_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 recv_val,
    output logic                                 recv_rdy,
    input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]      recv_msg,
    output logic                                 send_val,
    input  logic                                 send_rdy,
    output logic [ADDR_SIZE+PAYLOAD_SIZE:0]      send_msg,
    output logic [NUM_REGS*PAYLOAD_SIZE-1:0]     cfg_out,
    output logic [NUM_REGS-1:0]                  cfg_written
);
    localparam int MW = ADDR_SIZE + PAYLOAD_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] BASE = ADDR_SIZE'(BASE_ADDR);
    localparam logic [ADDR_SIZE:0] NREGS = (ADDR_SIZE + 1)'(NUM_REGS);

    logic [ADDR_SIZE-1:0]    addr, offset;
    logic                    op, hit, accept, consume;
    logic [PAYLOAD_SIZE-1:0] payload, rd_data;
    logic [MW-1:0]           fifo [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;

    assign addr     = recv_msg[MW-1 -: ADDR_SIZE];
    assign op       = recv_msg[PAYLOAD_SIZE];
    assign payload  = recv_msg[PAYLOAD_SIZE-1:0];
    assign offset   = addr - BASE;
    // The addr >= BASE term rejects addresses that wrap around below the bank.
    assign hit      = (addr >= BASE) && ({1'b0, offset} < NREGS);
    assign recv_rdy = count != 2'd2;
    assign send_val = count != 2'd0;
    assign send_msg = fifo[rd_ptr];
    assign accept   = recv_val && recv_rdy;
    assign consume  = send_val && send_rdy;

    // Select the addressed register for read responses
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (offset == ADDR_SIZE'(i)) rd_data = cfg_out[i*PAYLOAD_SIZE +: PAYLOAD_SIZE];
    end

    // Apply accepted write hits to the register bank and mark them written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_out     <= {NUM_REGS{RESET_VALUE}};
            cfg_written <= '0;
        end else if (accept && hit && op) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (offset == ADDR_SIZE'(i)) begin
                    cfg_out[i*PAYLOAD_SIZE +: PAYLOAD_SIZE] <= payload;
                    cfg_written[i] <= 1'b1;
                end
        end
    end

    // Queue one response per accepted request; occupancy alone drives recv_rdy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (accept) begin
                fifo[wr_ptr] <= {addr, hit, hit ? (op ? payload : rd_data) : {PAYLOAD_SIZE{1'b0}}};
                wr_ptr <= ~wr_ptr;
            end
            if (consume) rd_ptr <= ~rd_ptr;
            count <= count + 2'(accept) - 2'(consume);
        end
    end
endmodule

// File: tb/tb_config_reg_bank.sv
// tb_config_reg_bank: randomized and directed checks of two bank configurations against a queue model
module tb_config_reg_bank;
    logic        clk = 1'b0, reset = 1'b1, recv_val = 1'b0, send_rdy = 1'b0;
    logic [12:0] recv_msg = '0;
    logic        recv_rdy_a, send_val_a, recv_rdy_b, send_val_b;
    logic [12:0] send_msg_a, send_msg_b;
    logic [31:0] cfg_out_a;
    logic [23:0] cfg_out_b;
    logic [3:0]  cfg_written_a;
    logic [2:0]  cfg_written_b;

    int checks = 0, errors = 0;
    logic [7:0]  mr [2][16];
    logic        mw [2][16];
    logic [12:0] q0 [$];
    logic [12:0] q1 [$];

    config_reg_bank u_a (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_a), .recv_msg(recv_msg),
        .send_val(send_val_a), .send_rdy(send_rdy), .send_msg(send_msg_a),
        .cfg_out(cfg_out_a), .cfg_written(cfg_written_a)
    );

    config_reg_bank #(.NUM_REGS(3), .BASE_ADDR(4)) u_b (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_b), .recv_msg(recv_msg),
        .send_val(send_val_b), .send_rdy(send_rdy), .send_msg(send_msg_b),
        .cfg_out(cfg_out_b), .cfg_written(cfg_written_b)
    );

    always #5 clk = ~clk;

    function automatic int base_of(int k);
        return k ? 4 : 0;
    endfunction

    function automatic int nregs_of(int k);
        return k ? 3 : 4;
    endfunction

    function automatic logic [12:0] req(int a, bit op, int d);
        return {a[3:0], op, d[7:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                mr[k][i] = 8'h00;
                mw[k][i] = 1'b0;
            end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_req(int k, logic [12:0] m, output logic [12:0] r);
        int a, off;
        a = int'(m[12:9]);
        off = a - base_of(k);
        if (off >= 0 && off < nregs_of(k)) begin
            if (m[8]) begin
                mr[k][off] = m[7:0];
                mw[k][off] = 1'b1;
                r = {m[12:9], 1'b1, m[7:0]};
            end else begin
                r = {m[12:9], 1'b1, mr[k][off]};
            end
        end else begin
            r = {m[12:9], 9'b0};
        end
    endtask

    task automatic compare();
        logic [31:0] ea, eb;
        logic [3:0]  wa;
        logic [2:0]  wb;
        ea = '0; eb = '0; wa = '0; wb = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i*8 +: 8] = mr[0][i];
            wa[i] = mw[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            eb[i*8 +: 8] = mr[1][i];
            wb[i] = mw[1][i];
        end
        chk("recv_rdy_a", recv_rdy_a, q0.size() < 2);
        chk("recv_rdy_b", recv_rdy_b, q1.size() < 2);
        chk("send_val_a", send_val_a, q0.size() != 0);
        chk("send_val_b", send_val_b, q1.size() != 0);
        if (q0.size() != 0) chk("send_msg_a", send_msg_a, q0[0]);
        if (q1.size() != 0) chk("send_msg_b", send_msg_b, q1[0]);
        chk("cfg_out_a", cfg_out_a, ea);
        chk("cfg_out_b", cfg_out_b, eb);
        chk("cfg_written_a", cfg_written_a, wa);
        chk("cfg_written_b", cfg_written_b, wb);
    endtask

    task automatic cycle(bit v, logic [12:0] m, bit s);
        logic [12:0] r;
        bit acc, deq;
        recv_val = v;
        recv_msg = m;
        send_rdy = s;
        @(posedge clk);
        acc = v && q0.size() < 2;
        deq = q0.size() != 0 && s;
        if (deq) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (acc) begin
            model_req(0, m, r);
            q0.push_back(r);
            model_req(1, m, r);
            q1.push_back(r);
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_send_val", send_val_a, 0);
        chk("rst_recv_rdy", recv_rdy_a, 1);
        chk("rst_send_msg", send_msg_a, 0);
        chk("rst_cfg_out", cfg_out_a, 0);
        chk("rst_cfg_written", cfg_written_a, 0);
        reset = 1'b0;
        compare();

        cycle(1, req(2, 1, 'hA5), 1);
        chk("wr2_msg", send_msg_a, 13'h5A5);
        chk("wr2_val", send_val_a, 1);
        chk("wr2_cfg", cfg_out_a[23:16], 8'hA5);
        chk("wr2_written", cfg_written_a, 4'b0100);

        cycle(1, req(1, 1, 'h3C), 1);
        chk("raw_wr_msg", send_msg_a, 13'h33C);
        cycle(1, req(1, 0, 0), 1);
        chk("raw_rd_msg", send_msg_a, 13'h33C);
        chk("raw_rdy", recv_rdy_a, 1);

        cycle(1, req(9, 0, 0), 1);
        chk("miss_rd_msg", send_msg_a, 13'h1200);
        cycle(1, req(9, 1, 'hFF), 1);
        chk("miss_wr_msg", send_msg_a, 13'h1200);
        chk("miss_written", cfg_written_a, 4'b0110);
        cycle(0, '0, 1);

        cycle(1, req(0, 1, 'h10), 0);
        cycle(1, req(3, 1, 'h33), 0);
        chk("full_rdy", recv_rdy_a, 0);
        chk("full_head", send_msg_a, 13'h110);
        cycle(1, req(3, 0, 0), 1);
        chk("drain_rdy", recv_rdy_a, 1);
        chk("drain_head", send_msg_a, 13'h733);
        cycle(1, req(3, 0, 0), 1);
        cycle(0, '0, 1);
        cycle(0, '0, 1);

        cycle(1, req(6, 1, 'h11), 1);
        chk("b_hit_msg", send_msg_b, 13'hD11);
        chk("b_hit_cfg", cfg_out_b[23:16], 8'h11);
        cycle(1, req(7, 1, 'h22), 1);
        chk("b_miss7_msg", send_msg_b, 13'hE00);
        cycle(1, req(3, 1, 'h33), 1);
        chk("b_miss3_msg", send_msg_b, 13'h600);
        chk("b_written", cfg_written_b, 3'b100);
        cycle(0, '0, 1);

        cycle(1, req(0, 1, 'h55), 0);
        cycle(1, req(1, 1, 'h66), 0);
        recv_val = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_send_val", send_val_a, 0);
        chk("arst_recv_rdy", recv_rdy_a, 1);
        chk("arst_cfg_out", cfg_out_a, 0);
        chk("arst_written", cfg_written_a, 0);
        chk("arst_send_val_b", send_val_b, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        compare();
        cycle(0, '0, 1);
        cycle(0, '0, 1);

        for (int n = 0; n < 400; n++)
            cycle($urandom % 4 != 0, {4'($urandom % 8), 1'($urandom), 8'($urandom)}, $urandom % 3 != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
